// File: rtl/dmem_resp.sv
// Data-memory responder for the single-cycle mips core: word RAM plus an MMIO
// window holding LED, cycle/store counters, a countdown timer and a sticky error.
module dmem_resp #(
  parameter int ADDR_W = 10,
  parameter int LED_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  input  logic             memwrite,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led,
  output logic             timer_irq,
  output logic             misalign_err,
  output logic [1:0]       dbg_timer_state_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_CYCLE  = 16'h0004;
  localparam logic [15:0] OFF_STORES = 16'h0008;
  localparam logic [15:0] OFF_TIMER  = 16'h000C;
  localparam logic [15:0] OFF_STATUS = 16'h0010;

  logic [31:0] mem [2**ADDR_W];

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      stores_q, stores_d;
  logic [31:0]      count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             irq_q, irq_d;
  logic             err_q, err_d;

  logic              mmio_sel;
  logic [15:0]       off;
  logic              aligned;
  logic              reg_mapped;
  logic              store_ok;
  logic              mis_store;
  logic              ram_we;
  logic              led_wr;
  logic              timer_wr;
  logic              status_wr;
  logic              expire;
  logic [ADDR_W-1:0] ram_idx;

  // There is no handshake: memwrite is a one-cycle strobe taken at the rising
  // edge, and reads are answered combinationally in the same cycle.
  assign mmio_sel   = (addr[31:16] == 16'hFFFF);
  assign off        = addr[15:0];
  assign aligned    = (addr[1:0] == 2'b00);
  assign ram_idx    = addr[ADDR_W+1:2];
  assign reg_mapped = (off == OFF_LED) || (off == OFF_CYCLE) || (off == OFF_STORES) ||
                      (off == OFF_TIMER) || (off == OFF_STATUS);

  assign store_ok  = memwrite && aligned && (!mmio_sel || reg_mapped);
  assign mis_store = memwrite && !aligned;
  assign ram_we    = store_ok && !mmio_sel;
  assign led_wr    = store_ok && mmio_sel && (off == OFF_LED);
  assign timer_wr  = store_ok && mmio_sel && (off == OFF_TIMER);
  assign status_wr = store_ok && mmio_sel && (off == OFF_STATUS);

  always_comb begin
    readdata = '0;
    if (mmio_sel) begin
      case (off)
        OFF_LED:    readdata[LED_W-1:0] = led_q;
        OFF_CYCLE:  readdata = cycle_q;
        OFF_STORES: readdata = stores_q;
        OFF_TIMER:  readdata = count_q;
        OFF_STATUS: readdata = {29'b0, err_q, irq_q, (state_q == ST_RUN)};
        default:    readdata = '0;
      endcase
    end else begin
      readdata = mem[ram_idx];
    end
  end

  // A reload always wins over the decrement and suppresses that cycle's expiry.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    expire  = 1'b0;
    if (timer_wr) begin
      count_d = writedata;
      state_d = (writedata != 32'd0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN) begin
      count_d = count_q - 32'd1;
      if (count_q == 32'd1) begin
        state_d = ST_EXPIRED;
        expire  = 1'b1;
      end
    end
  end

  always_comb begin
    led_d    = led_wr ? writedata[LED_W-1:0] : led_q;
    cycle_d  = cycle_q + 32'd1;
    stores_d = store_ok ? stores_q + 32'd1 : stores_q;
    irq_d    = irq_q;
    err_d    = err_q;
    // Setting events beat a simultaneous software clear.
    if (expire) begin
      irq_d = 1'b1;
    end else if (status_wr && writedata[0]) begin
      irq_d = 1'b0;
    end
    if (mis_store) begin
      err_d = 1'b1;
    end else if (status_wr && writedata[1]) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q    <= '0;
      cycle_q  <= '0;
      stores_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      count_q  <= count_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= writedata;
    end
  end

  assign led               = led_q;
  assign timer_irq         = irq_q;
  assign misalign_err      = err_q;
  assign dbg_timer_state_o = state_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios plus a randomized run, all checked
// against a memory-map level reference model.
module tb_dmem_resp;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [15:0] led;
  logic        timer_irq;
  logic        misalign_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  // reference model
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_cycle;
  logic [31:0] m_stores;
  logic [31:0] m_count;
  logic        m_running;
  logic        m_irq;
  logic        m_err;

  dmem_resp #(.ADDR_W(10), .LED_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .writedata         (writedata),
    .memwrite          (memwrite),
    .readdata          (readdata),
    .led               (led),
    .timer_irq         (timer_irq),
    .misalign_err      (misalign_err),
    .dbg_timer_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0000: r = {16'd0, m_led};
        16'h0004: r = m_cycle;
        16'h0008: r = m_stores;
        16'h000C: r = m_count;
        16'h0010: r = {29'd0, m_err, m_irq, m_running};
        default:  r = 32'd0;
      endcase
    end else if (m_mem.exists(int'(a[11:2]))) begin
      r = m_mem[int'(a[11:2])];
    end else begin
      r = 'x;
    end
    return r;
  endfunction

  function automatic void model_step(input logic [31:0] a, input logic [31:0] wd,
                                     input logic we, input logic r);
    logic        mm, al, mapped, acc, expire;
    logic [15:0] o;
    if (!r) begin
      m_led = 0; m_cycle = 0; m_stores = 0; m_count = 0;
      m_running = 0; m_irq = 0; m_err = 0;
      return;
    end
    mm     = (a[31:16] == 16'hFFFF);
    o      = a[15:0];
    al     = (a[1:0] == 2'b00);
    mapped = (o == 16'h0) || (o == 16'h4) || (o == 16'h8) || (o == 16'hC) || (o == 16'h10);
    acc    = we && al && (!mm || mapped);
    expire = 1'b0;
    m_cycle = m_cycle + 1;
    if (acc) m_stores = m_stores + 1;
    if (acc && !mm) m_mem[int'(a[11:2])] = wd;
    if (acc && mm && o == 16'h0) m_led = wd[15:0];
    if (acc && mm && o == 16'hC) begin
      m_count   = wd;
      m_running = (wd != 0);
    end else if (m_running) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_running = 0;
        expire    = 1;
      end
    end
    if (expire) m_irq = 1;
    else if (acc && mm && o == 16'h10 && wd[0]) m_irq = 0;
    if (we && !al) m_err = 1;
    else if (acc && mm && o == 16'h10 && wd[1]) m_err = 0;
  endfunction

  // One clock: drive at the falling edge, sample readdata before the rising
  // edge, advance the model on the edge, then settle.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic r, output logic [31:0] obs, output logic [31:0] exp);
    @(negedge clk);
    addr = a; writedata = wd; memwrite = we; rst = r;
    #1;
    obs = readdata;
    exp = model_read(a);
    @(posedge clk);
    model_step(a, wd, we, r);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] o, e;
    step(a, wd, 1'b1, 1'b1, o, e);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] obs, output logic [31:0] exp);
    step(a, 32'd0, 1'b0, 1'b1, obs, exp);
  endtask

  task automatic idle();
    logic [31:0] o, e;
    step(32'd0, 32'd0, 1'b0, 1'b1, o, e);
  endtask

  task automatic test_reset();
    logic [31:0] o, e;
    step(32'd0, 32'd0, 1'b0, 1'b0, o, e);
    step(32'd0, 32'd0, 1'b0, 1'b0, o, e);
    checks++;
    if (led !== 16'd0 || timer_irq !== 1'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: led=%h irq=%b err=%b required 0/0/0", led, timer_irq, misalign_err);
    end
    rd(32'hFFFF0004, o, e);
    checks++;
    if (o !== 32'd0 || o !== e) begin
      errors++;
      $display("FAIL reset_cycle0: got %h required 0", o);
    end
    rd(32'hFFFF0004, o, e);
    checks++;
    if (o !== 32'd1 || o !== e) begin
      errors++;
      $display("FAIL reset_cycle1: got %h required 1", o);
    end
    rd(32'hFFFF0008, o, e);
    checks++;
    if (o !== 32'd0) begin
      errors++;
      $display("FAIL reset_stores: got %h required 0", o);
    end
  endtask

  task automatic test_ram();
    logic [31:0] o, e;
    wr(32'h0000_0010, 32'hDEADBEEF);
    rd(32'h0000_0010, o, e);
    checks++;
    if (o !== 32'hDEADBEEF || o !== e) begin
      errors++;
      $display("FAIL ram_read: got %h required deadbeef", o);
    end
    rd(32'h0000_1010, o, e);
    checks++;
    if (o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ram_alias: got %h required deadbeef", o);
    end
    rd(32'h0000_0012, o, e);
    checks++;
    if (o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ram_misaligned_read: got %h required deadbeef", o);
    end
    rd(32'hFFFF0008, o, e);
    checks++;
    if (o !== 32'd1 || o !== e) begin
      errors++;
      $display("FAIL ram_stores: got %h required 1", o);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] o, e;
    wr(32'h0000_0013, 32'h11111111);
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_set: err=%b required 1", misalign_err);
    end
    rd(32'h0000_0010, o, e);
    checks++;
    if (o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misalign_ram: got %h required deadbeef", o);
    end
    rd(32'hFFFF0008, o, e);
    checks++;
    if (o !== 32'd1) begin
      errors++;
      $display("FAIL misalign_stores: got %h required 1", o);
    end
    wr(32'hFFFF0010, 32'h2);
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: err=%b required 0", misalign_err);
    end
  endtask

  task automatic test_timer();
    logic [31:0] o, e;
    int edges;
    wr(32'hFFFF000C, 32'd5);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (timer_irq === 1'b1) begin
        edges = i;
        break;
      end
    end
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL timer_expiry_edges: got %0d required 5", edges);
    end
    rd(32'hFFFF000C, o, e);
    checks++;
    if (o !== 32'd0) begin
      errors++;
      $display("FAIL timer_count_zero: got %h required 0", o);
    end
    wr(32'hFFFF0010, 32'h1);
    wr(32'hFFFF000C, 32'd5);
    idle(); idle(); idle();
    rd(32'hFFFF000C, o, e);
    checks++;
    if (o !== 32'd2 || o !== e) begin
      errors++;
      $display("FAIL timer_count_two: got %h required 2", o);
    end
    wr(32'hFFFF000C, 32'd3);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (timer_irq === 1'b1) begin
        edges = i;
        break;
      end
    end
    checks++;
    if (edges != 3) begin
      errors++;
      $display("FAIL timer_reload_edges: got %0d required 3", edges);
    end
  endtask

  task automatic test_coincide();
    wr(32'hFFFF0010, 32'h1);
    wr(32'hFFFF000C, 32'd2);
    idle();
    wr(32'hFFFF0010, 32'h1);
    checks++;
    if (timer_irq !== 1'b1 || timer_irq !== m_irq) begin
      errors++;
      $display("FAIL coincide_set_wins: irq=%b required 1", timer_irq);
    end
    wr(32'hFFFF0010, 32'h1);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL coincide_clear: irq=%b required 0", timer_irq);
    end
  endtask

  task automatic test_led();
    logic [31:0] o, e, s1, s2;
    wr(32'hFFFF0000, 32'h1234ABCD);
    checks++;
    if (led !== 16'hABCD) begin
      errors++;
      $display("FAIL led_out: got %h required abcd", led);
    end
    rd(32'hFFFF0000, o, e);
    checks++;
    if (o !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL led_read: got %h required 0000abcd", o);
    end
    rd(32'hFFFF0020, o, e);
    checks++;
    if (o !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read: got %h required 0", o);
    end
    rd(32'hFFFF0008, s1, e);
    wr(32'hFFFF0020, 32'hFFFFFFFF);
    rd(32'hFFFF0008, s2, e);
    checks++;
    if (s2 !== s1 || s2 !== e) begin
      errors++;
      $display("FAIL unmapped_write_stores: got %h required %h", s2, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] o, e;
    wr(32'h0000_0021, 32'h0);
    wr(32'hFFFF000C, 32'd10);
    idle(); idle();
    step(32'd0, 32'd0, 1'b0, 1'b0, o, e);
    checks++;
    if (led !== 16'd0 || timer_irq !== 1'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: led=%h irq=%b err=%b required 0/0/0", led, timer_irq, misalign_err);
    end
    rd(32'hFFFF0004, o, e);
    checks++;
    if (o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_cycle0: got %h required 0", o);
    end
    rd(32'hFFFF0010, o, e);
    checks++;
    if (o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_status: got %h required 0", o);
    end
    rd(32'h0000_0010, o, e);
    checks++;
    if (o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midreset_ram_kept: got %h required deadbeef", o);
    end
    for (int i = 0; i < 12; i++) idle();
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_irq: irq=%b required 0", timer_irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] o, e, a, wd;
    logic        we;
    logic [15:0] offs [6];
    offs[0] = 16'h0; offs[1] = 16'h4; offs[2] = 16'h8;
    offs[3] = 16'hC; offs[4] = 16'h10; offs[5] = 16'h20;
    for (int k = 0; k < 8; k++) wr(32'(k * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      wd = $urandom;
      we = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          a  = 32'($urandom_range(0, 7) * 4) | (32'($urandom_range(0, 3)) << 12);
          we = 1'b1;
        end
        3, 4: a = 32'($urandom_range(0, 7) * 4) | (32'($urandom_range(0, 3)) << 12)
                  | 32'($urandom_range(0, 3));
        5: begin
          a  = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
          if ($urandom_range(0, 1) == 1) a = a | 32'hFFFF0000;
          we = 1'b1;
        end
        6: a = {16'hFFFF, offs[$urandom_range(0, 5)]};
        7: begin
          a  = {16'hFFFF, offs[$urandom_range(0, 5)]};
          if (a[15:0] == 16'hC) wd = 32'($urandom_range(0, 6));
          we = 1'b1;
        end
        8: begin
          a  = 32'hFFFF000C;
          wd = 32'($urandom_range(0, 6));
          we = 1'b1;
        end
        default: a = 32'hFFFF0010;
      endcase
      step(a, wd, we, 1'b1, o, e);
      exp_q.push_back(e);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_readdata n=%0d addr=%h: got %h required %h", n, a, o, e);
      end
      checks++;
      if (led !== m_led || timer_irq !== m_irq || misalign_err !== m_err) begin
        errors++;
        $display("FAIL rand_outputs n=%0d: led=%h irq=%b err=%b required %h/%b/%b",
                 n, led, timer_irq, misalign_err, m_led, m_irq, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b0; addr = 32'd0; writedata = 32'd0; memwrite = 1'b0;
    test_reset();
    test_ram();
    test_misalign();
    test_timer();
    test_coincide();
    test_led();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
